// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter with an ack watchdog in front of the SRAM controller.
// Optional macro WB_ARB_ROUND_ROBIN_EN: an IDLE tie goes to the master not granted most recently.
module wb_ram_arbiter #(
    parameter int WB_ADDR_WIDTH      = 20,
    parameter int DATA_WIDTH         = 8,
    parameter int ACK_TIMEOUT_CYCLES = 16,
    parameter int MAX_OUTSTANDING    = 2
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_ni,
    input  logic [WB_ADDR_WIDTH-1:0] m0_wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    m0_wb_data_i,
    output logic [DATA_WIDTH-1:0]    m0_wb_data_o,
    input  logic                     m0_wb_we_i,
    input  logic                     m0_wb_cycle_i,
    input  logic                     m0_wb_strobe_i,
    output logic                     m0_wb_stall_o,
    output logic                     m0_wb_ack_o,
    output logic                     m0_wb_err_o,
    input  logic [WB_ADDR_WIDTH-1:0] m1_wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    m1_wb_data_i,
    output logic [DATA_WIDTH-1:0]    m1_wb_data_o,
    input  logic                     m1_wb_we_i,
    input  logic                     m1_wb_cycle_i,
    input  logic                     m1_wb_strobe_i,
    output logic                     m1_wb_stall_o,
    output logic                     m1_wb_ack_o,
    output logic                     m1_wb_err_o,
    output logic [WB_ADDR_WIDTH-1:0] s_wb_addr_o,
    output logic [DATA_WIDTH-1:0]    s_wb_data_o,
    output logic                     s_wb_we_o,
    output logic                     s_wb_cycle_o,
    output logic                     s_wb_strobe_o,
    input  logic [DATA_WIDTH-1:0]    s_wb_data_i,
    input  logic                     s_wb_stall_i,
    input  logic                     s_wb_ack_i,
    output logic [1:0]               grant_o
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;

    state_t        r_state;
    logic [1:0]    r_grant;
    logic [1:0]    r_err;
    logic [OW-1:0] r_outst;
    logic [7:0]    r_wdog;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic          r_last_m1;
`endif

    logic w_busy, w_cyc, w_stb, w_cap, w_pend, w_accept, w_timeout;
    logic w_req0, w_req1, w_pick_m1;

    assign w_busy = (r_state == GRANTED);
    assign w_cyc  = r_grant[1] ? m1_wb_cycle_i  : m0_wb_cycle_i;
    assign w_stb  = r_grant[1] ? m1_wb_strobe_i : m0_wb_strobe_i;
    assign w_cap  = (r_outst == OW'(MAX_OUTSTANDING));
    assign w_pend = (r_outst != '0);

    // Slave cyc stays up after the master drops it until every accepted strobe is acked.
    assign s_wb_cycle_o  = w_busy & (w_cyc | w_pend);
    assign s_wb_strobe_o = w_busy & w_cyc & w_stb & ~w_cap;
    assign s_wb_addr_o   = r_grant[1] ? m1_wb_addr_i : m0_wb_addr_i;
    assign s_wb_data_o   = r_grant[1] ? m1_wb_data_i : m0_wb_data_i;
    assign s_wb_we_o     = r_grant[1] ? m1_wb_we_i   : m0_wb_we_i;

    assign w_accept  = s_wb_strobe_o & ~s_wb_stall_i;
    assign w_timeout = w_pend & ~s_wb_ack_i & (r_wdog == 8'(ACK_TIMEOUT_CYCLES - 1));

    assign m0_wb_stall_o = ~(w_busy & r_grant[0]) | s_wb_stall_i | w_cap;
    assign m1_wb_stall_o = ~(w_busy & r_grant[1]) | s_wb_stall_i | w_cap;
    assign m0_wb_ack_o   = w_busy & r_grant[0] & s_wb_ack_i;
    assign m1_wb_ack_o   = w_busy & r_grant[1] & s_wb_ack_i;
    assign m0_wb_err_o   = r_err[0];
    assign m1_wb_err_o   = r_err[1];
    assign m0_wb_data_o  = s_wb_data_i;
    assign m1_wb_data_o  = s_wb_data_i;
    assign grant_o       = r_grant;

    assign w_req0 = m0_wb_cycle_i & m0_wb_strobe_i;
    assign w_req1 = m1_wb_cycle_i & m1_wb_strobe_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
    assign w_pick_m1 = w_req1 & (~w_req0 | ~r_last_m1);
`else
    assign w_pick_m1 = w_req1 & ~w_req0;
`endif

    always_ff @(posedge wb_clock_i) begin
        if (!wb_reset_ni) begin
            r_state   <= IDLE;
            r_grant   <= 2'b00;
            r_err     <= 2'b00;
            r_outst   <= '0;
            r_wdog    <= 8'd0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            r_last_m1 <= 1'b1;
`endif
        end else begin
            r_err <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_state <= GRANTED;
                        r_grant <= w_pick_m1 ? 2'b10 : 2'b01;
`ifdef WB_ARB_ROUND_ROBIN_EN
                        r_last_m1 <= w_pick_m1;
`endif
                    end
                end
                GRANTED: begin
                    if (w_timeout) begin
                        r_state <= ABORT;
                        r_err   <= r_grant;
                        r_grant <= 2'b00;
                        r_outst <= '0;
                        r_wdog  <= 8'd0;
                    end else begin
                        if (!w_cyc && !w_pend) begin
                            r_state <= IDLE;
                            r_grant <= 2'b00;
                        end
                        r_wdog <= (!w_pend || s_wb_ack_i) ? 8'd0 : r_wdog + 8'd1;
                        // A stray ack with nothing outstanding is passed on but never underflows.
                        if (w_accept && !(s_wb_ack_i && w_pend))
                            r_outst <= r_outst + OW'(1);
                        else if (!w_accept && s_wb_ack_i && w_pend)
                            r_outst <= r_outst - OW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: directed cycle tables, hand sequences, and random traffic against a model.
module tb_wb_ram_arbiter;
    localparam int AW = 20, DW = 8, TO = 16, MO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
    logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic          m0_stall, m1_stall, m0_ack, m1_ack, m0_err, m1_err;
    logic          s_we, s_cyc, s_stb, s_stall, s_ack;
    logic [1:0]    grant;

    wb_ram_arbiter #(.WB_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .ACK_TIMEOUT_CYCLES(TO), .MAX_OUTSTANDING(MO)) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n),
        .m0_wb_addr_i(m0_addr), .m0_wb_data_i(m0_wdat), .m0_wb_data_o(m0_rdat),
        .m0_wb_we_i(m0_we), .m0_wb_cycle_i(m0_cyc), .m0_wb_strobe_i(m0_stb),
        .m0_wb_stall_o(m0_stall), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
        .m1_wb_addr_i(m1_addr), .m1_wb_data_i(m1_wdat), .m1_wb_data_o(m1_rdat),
        .m1_wb_we_i(m1_we), .m1_wb_cycle_i(m1_cyc), .m1_wb_strobe_i(m1_stb),
        .m1_wb_stall_o(m1_stall), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
        .s_wb_addr_o(s_addr), .s_wb_data_o(s_wdat), .s_wb_we_o(s_we),
        .s_wb_cycle_o(s_cyc), .s_wb_strobe_o(s_stb),
        .s_wb_data_i(s_rdat), .s_wb_stall_i(s_stall), .s_wb_ack_i(s_ack),
        .grant_o(grant)
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // in = {rst_n, m0 cyc,stb,we, m1 cyc,stb,we, s_stall, s_ack}
    task automatic drive(input logic [8:0] in);
        {rst_n, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_stall, s_ack} = in;
    endtask

    // ex = {grant[1:0], m0_stall, m1_stall, m0_ack, m1_ack, s_cyc, s_stb}
    task automatic cyc_chk(input string nm, input logic [8:0] in, input logic [7:0] ex,
                           input logic [1:0] eerr);
        logic [7:0] e;
        e = ex;
        drive(in);
        #1;
        chk(nm, {grant, m0_stall, m1_stall, m0_ack, m1_ack, s_cyc, s_stb, m1_err, m0_err},
            {e, eerr});
        if (e[0]) begin
            chk({nm, " addr"}, s_addr, e[7] ? 20'h0ABCD : 20'h01234);
            chk({nm, " wdat/we"}, {s_wdat, s_we}, e[7] ? {8'h5A, in[2]} : {8'h11, in[5]});
        end
        if (e[3] | e[2]) chk({nm, " rdat"}, {m1_rdat, m0_rdat}, 16'hA5A5);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        string      nm;
        logic [8:0] in;
        logic [7:0] ex;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string nm, input logic [8:0] in, input logic [7:0] ex);
        vec_t v;
        v.nm = nm; v.in = in; v.ex = ex;
        tbl.push_back(v);
    endtask

    // Reference model: owner 0=none,1=M0,2=M1; pend = accepted-but-unacked; quiet = ack-less cycles.
    int own, abt, pend, quiet, last;

    task automatic mdl_expect(output logic [1:0] eg, output logic [1:0] est, output logic [1:0] eack,
                              output logic [1:0] eerr, output logic esc, output logic ess);
        logic c, s, busy, full;
        busy = (own != 0);
        c    = (own == 2) ? m1_cyc : m0_cyc;
        s    = (own == 2) ? m1_stb : m0_stb;
        full = (pend >= MO);
        eg   = {own == 2, own == 1};
        esc  = busy && (c || pend > 0);
        ess  = busy && c && s && !full;
        est  = {own != 2 || s_stall || full, own != 1 || s_stall || full};
        eack = {own == 2 && s_ack, own == 1 && s_ack};
        eerr = {abt == 2, abt == 1};
    endtask

    task automatic mdl_update();
        logic c, acc;
        logic [1:0] d2;
        logic d1, ss;
        bit r0, r1;
        if (!rst_n) begin
            own = 0; abt = 0; pend = 0; quiet = 0; last = 2;
        end else if (abt != 0) begin
            abt = 0;
        end else if (own == 0) begin
            r0 = m0_cyc && m0_stb;
            r1 = m1_cyc && m1_stb;
            if (r0 && r1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                own = (last == 1) ? 2 : 1;
`else
                own = 1;
`endif
            end else if (r0) own = 1;
            else if (r1) own = 2;
            if (own != 0) last = own;
        end else begin
            mdl_expect(d2, d2, d2, d2, d1, ss);
            c   = (own == 2) ? m1_cyc : m0_cyc;
            acc = ss && !s_stall;
            if (pend > 0 && !s_ack && quiet + 1 == TO) begin
                abt = own; own = 0; pend = 0; quiet = 0;
            end else begin
                quiet = (pend == 0 || s_ack) ? 0 : quiet + 1;
                if (!c && pend == 0) own = 0;
                pend = pend + int'(acc) - ((s_ack && pend > 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        logic [1:0] g, eg, est, eack, eerr;
        logic       esc, ess, rr;
        drive(9'b0_000_000_00);
        m0_addr = 20'h01234; m0_wdat = 8'h11;
        m1_addr = 20'h0ABCD; m1_wdat = 8'h5A;
        s_rdat  = 8'hA5;
        @(negedge clk);
        @(negedge clk);

        add("reset",         9'b0_000_000_00, 8'b00_11_00_00);
        add("s1 req stall",  9'b1_110_000_00, 8'b00_11_00_00);
        add("s1 grant",      9'b1_110_000_00, 8'b01_01_00_11);
        for (int k = 0; k < 4; k++)
            add("s1 wait",   9'b1_100_000_00, 8'b01_01_00_10);
        add("s1 ack",        9'b1_100_000_01, 8'b01_01_10_10);
        add("s1 release",    9'b1_000_000_00, 8'b01_01_00_00);
        add("s1 idle",       9'b1_000_000_00, 8'b00_11_00_00);
        add("s2 reset",      9'b0_000_000_00, 8'b00_11_00_00);
        add("s2 tie idle",   9'b1_110_111_00, 8'b00_11_00_00);
        add("s2 m0 wins",    9'b1_110_111_00, 8'b01_01_00_11);
        add("s2 m0 ack",     9'b1_100_111_01, 8'b01_01_10_10);
        add("s2 m0 release", 9'b1_000_111_00, 8'b01_01_00_00);
        add("s2 m1 wait",    9'b1_000_111_00, 8'b00_11_00_00);
        add("s2 m1 write",   9'b1_000_111_00, 8'b10_10_00_11);
        add("s2 m1 ack",     9'b1_000_100_01, 8'b10_10_01_10);
        add("s2 m1 release", 9'b1_000_000_00, 8'b10_10_00_00);
        add("s2 idle",       9'b1_000_000_00, 8'b00_11_00_00);
        add("s3 idle",       9'b1_000_110_00, 8'b00_11_00_00);
        add("s3 stb1",       9'b1_000_110_00, 8'b10_10_00_11);
        add("s3 stb2",       9'b1_000_110_00, 8'b10_10_00_11);
        add("s3 cap stall",  9'b1_000_110_00, 8'b10_11_00_10);
        add("s3 ack1 cap",   9'b1_000_110_01, 8'b10_11_01_10);
        add("s3 stb3",       9'b1_000_110_00, 8'b10_10_00_11);
        add("s3 ack2 cap",   9'b1_000_100_01, 8'b10_11_01_10);
        add("s3 ack3 drain", 9'b1_000_000_01, 8'b10_10_01_10);
        add("s3 release",    9'b1_000_000_00, 8'b10_10_00_00);
        add("s3 idle",       9'b1_000_000_00, 8'b00_11_00_00);
        foreach (tbl[i]) cyc_chk(tbl[i].nm, tbl[i].in, tbl[i].ex, 2'b00);

        // Watchdog: M0 never acked, M1 waiting behind it.
        cyc_chk("to idle",  9'b1_110_110_00, 8'b00_11_00_00, 2'b00);
        cyc_chk("to grant", 9'b1_110_110_00, 8'b01_01_00_11, 2'b00);
        for (int k = 0; k < TO; k++)
            cyc_chk("to wait", 9'b1_100_110_00, 8'b01_01_00_10, 2'b00);
        cyc_chk("to abort",    9'b1_100_110_00, 8'b00_11_00_00, 2'b01);
        cyc_chk("to idle2",    9'b1_000_110_00, 8'b00_11_00_00, 2'b00);
        cyc_chk("to m1 grant", 9'b1_000_110_00, 8'b10_10_00_11, 2'b00);
        cyc_chk("to m1 ack",   9'b1_000_100_01, 8'b10_10_01_10, 2'b00);
        cyc_chk("to m1 rel",   9'b1_000_000_00, 8'b10_10_00_00, 2'b00);

        // Reset while a strobe is outstanding; the late ack must not reach M0.
        cyc_chk("rs idle",   9'b1_110_000_00, 8'b00_11_00_00, 2'b00);
        cyc_chk("rs grant",  9'b1_110_000_00, 8'b01_01_00_11, 2'b00);
        cyc_chk("rs assert", 9'b0_100_000_00, 8'b01_01_00_10, 2'b00);
        cyc_chk("rs late",   9'b1_100_000_01, 8'b00_11_00_00, 2'b00);
        cyc_chk("rs idle2",  9'b1_000_000_00, 8'b00_11_00_00, 2'b00);

        // Both masters keep requesting; slave stalls so each grant releases immediately.
        for (int r = 0; r < 3; r++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            rr = (r == 1);
`else
            rr = 1'b0;
`endif
            g = rr ? 2'b10 : 2'b01;
            cyc_chk("rr idle",    9'b1_110_110_10, 8'b00_11_00_00, 2'b00);
            cyc_chk("rr grant",   9'b1_110_110_10, {g, 6'b11_00_11}, 2'b00);
            cyc_chk("rr release", rr ? 9'b1_110_000_10 : 9'b1_000_110_10, {g, 6'b11_00_00}, 2'b00);
        end

        // Random traffic against the model.
        drive(9'b0_000_000_00);
        #1;
        mdl_update();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            m0_cyc  = ($urandom_range(0, 3) != 0);
            m0_stb  = $urandom_range(0, 1) == 1;
            m0_we   = $urandom_range(0, 1) == 1;
            m1_cyc  = ($urandom_range(0, 3) != 0);
            m1_stb  = $urandom_range(0, 1) == 1;
            m1_we   = $urandom_range(0, 1) == 1;
            s_stall = ($urandom_range(0, 3) == 0);
            s_ack   = ((i / 500) % 2 == 1) ? ($urandom_range(0, 39) == 0)
                                           : ($urandom_range(0, 2) == 0);
            m0_addr = AW'($urandom); m1_addr = AW'($urandom);
            m0_wdat = DW'($urandom); m1_wdat = DW'($urandom); s_rdat = DW'($urandom);
            #1;
            mdl_expect(eg, est, eack, eerr, esc, ess);
            chk("rnd grant", grant, eg);
            chk("rnd stall", {m1_stall, m0_stall}, est);
            chk("rnd ack", {m1_ack, m0_ack}, eack);
            chk("rnd err", {m1_err, m0_err}, eerr);
            chk("rnd s_cyc/stb", {s_cyc, s_stb}, {esc, ess});
            chk("rnd rdata", {m1_rdat, m0_rdat}, {s_rdat, s_rdat});
            if (ess)
                chk("rnd s_addr/we", {s_addr, s_wdat, s_we},
                    (own == 2) ? {m1_addr, m1_wdat, m1_we} : {m0_addr, m0_wdat, m0_we});
            mdl_update();
            @(posedge clk);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/wb_ram_arbiter.md
Name: wb_ram_arbiter

Overview:
Two-master, one-slave Wishbone B4 pipelined arbiter that shares the external SRAM controller between the CPU-side bus master (M0) and the SPI/host-side bus master (M1). It locks a grant per master bus cycle (cyc) and routes strobe, stall, ack and data. A watchdog aborts transfers whose ack never arrives, so a stalled slave cannot hang the system.

Parameters:
ACK_TIMEOUT_CYCLES, 16, cycles with a transfer outstanding and no slave ack before abort (range 2..255)
MAX_OUTSTANDING, 2, maximum accepted-but-unacked strobes per grant; further strobes stalled

Ports:
wb_clock_i  in  1  system clock; all logic on rising edge
wb_reset_ni  in  1  synchronous active-low reset
m0_wb_addr_i / m1_wb_addr_i  in  WB_ADDR_WIDTH  master address
m0_wb_data_i / m1_wb_data_i  in  DATA_WIDTH  master write data
m0_wb_data_o / m1_wb_data_o  out  DATA_WIDTH  read data (slave data, passed through)
m0_wb_we_i / m1_wb_we_i  in  1  write enable
m0_wb_cycle_i / m1_wb_cycle_i  in  1  bus cycle request
m0_wb_strobe_i / m1_wb_strobe_i  in  1  transfer strobe
m0_wb_stall_o / m1_wb_stall_o  out  1  stall to master
m0_wb_ack_o / m1_wb_ack_o  out  1  transfer ack
m0_wb_err_o / m1_wb_err_o  out  1  one-cycle pulse on watchdog abort
s_wb_addr_o, s_wb_data_o, s_wb_we_o  out  WB_ADDR_WIDTH/DATA_WIDTH/1  to slave
s_wb_cycle_o, s_wb_strobe_o  out  1  to slave
s_wb_data_i, s_wb_stall_i, s_wb_ack_i  in  DATA_WIDTH/1/1  from slave
grant_o  out  2  one-hot current grant (00 = none), debug/status

Behaviour:
- Reset (wb_reset_ni=0 at edge): state IDLE, grant_o=00, outstanding=0, watchdog=0, all stall_o=1, ack_o=0, err_o=0, s_wb_cycle_o=0, s_wb_strobe_o=0. Reset mid-transfer drops slave cyc the next cycle; any pending ack is discarded.
- States: IDLE -> GRANTED -> (IDLE | ABORT). ABORT -> IDLE after exactly one cycle.
- IDLE: both stall_o=1, slave cyc/stb=0. At an edge where any mN_cycle_i & mN_strobe_i: register grant (fixed priority M0 > M1) and go GRANTED. A request therefore sees stall for at least 1 cycle.
- GRANTED (master g): s_wb_cycle_o=mg_cycle_i; s_wb_strobe_o=mg_strobe_i & !cap; addr/data/we muxed from g combinationally. cap = (outstanding==MAX_OUTSTANDING). mg_stall_o = s_wb_stall_i | cap; other master stall_o=1, ack_o=0.
- outstanding: +1 on s_wb_strobe_o & !s_wb_stall_i, -1 on s_wb_ack_i; both in the same cycle leaves it unchanged. A stray ack at outstanding=0 is forwarded but does not underflow.
- mg_wb_ack_o = s_wb_ack_i (combinational); mN_wb_data_o = s_wb_data_i for both masters.
- Release: when mg_cycle_i=0 and outstanding=0, go IDLE at that edge. When mg_cycle_i drops with outstanding>0, hold grant with slave cyc forced high until the count drains (no ack is lost).
- Watchdog: counts cycles where outstanding>0 & !s_wb_ack_i; clears on any ack or when outstanding=0. Reaching ACK_TIMEOUT_CYCLES -> ABORT: mg_wb_err_o=1 for one cycle, s_wb_cycle_o=0, outstanding cleared, grant cleared.
- Fairness with both requesting at release: M0 wins under fixed priority (default).

Optional Feature:
WB_ARB_ROUND_ROBIN_EN: when defined, an IDLE tie is awarded to the master not granted most recently (reset history = M1 last, so M0 wins the first tie). When undefined, fixed priority M0 > M1 always applies.

Test Plan:
- Single M0 read of addr 0x0_1234 with the slave acking after 5 cycles -> stall 1 cycle, grant_o=01, m0_ack 1 cycle with slave data 0xA5, back to IDLE with grant_o=00 after cyc drops.
- M0 and M1 assert cyc/stb on the same cycle -> M0 granted; M1 stall stays 1 until M0 cyc drops; M1 then granted and writes 0x5A with one ack.
- Pipelined M1: 3 strobes with MAX_OUTSTANDING=2 -> third stalled until the first ack; exactly 3 acks; outstanding returns to 0.
- Slave never acks, ACK_TIMEOUT_CYCLES=16 -> m0_err pulse 16 cycles after acceptance, s_wb_cycle_o=0 the next cycle, grant released, pending M1 granted afterwards.
- wb_reset_ni=0 while GRANTED with outstanding=1 -> next cycle all outputs at reset values; a late ack is not forwarded.
- WB_ARB_ROUND_ROBIN_EN defined, both masters continuously requesting -> grants alternate 01, 10, 01.
